// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

  // Counter must hold DATA_WIDTH itself, not just DATA_WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/divider_seq_param_if.sv
// Start/done handshake and result bus of the sequential divider.
interface divider_seq_param_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  start_in;
  logic [DATA_WIDTH-1:0] dividend_in;
  logic [DATA_WIDTH-1:0] divisor_in;
  logic                  busy_out;
  logic                  done_out;
  logic [DATA_WIDTH-1:0] quotient_out;
  logic [DATA_WIDTH-1:0] remainder_out;
  logic                  div_by_zero_out;

  modport master (
    output start_in, dividend_in, divisor_in,
    input  busy_out, done_out, quotient_out, remainder_out, div_by_zero_out
  );

  modport slave (
    input  start_in, dividend_in, divisor_in,
    output busy_out, done_out, quotient_out, remainder_out, div_by_zero_out
  );
endinterface

// File: rtl/sub_param.sv
// Parametric ripple-free subtractor: diff = a - b - bor_in, with borrow out.
module sub_param #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  bor_in,
  output logic [DATA_WIDTH-1:0] diff_out,
  output logic                  bor_out
);
  assign {bor_out, diff_out} = {1'b0, a_in} - {1'b0, b_in} - {{DATA_WIDTH{1'b0}}, bor_in};
endmodule

// File: rtl/divider_seq_param.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional feature: define DIV_ZERO_DETECT_EN to short-cut zero divisors straight to DONE.
module divider_seq_param
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  divider_seq_param_if.slave bus
);
  localparam int unsigned CntW = cnt_width(DATA_WIDTH);
  localparam int unsigned RemW = DATA_WIDTH + 1;

  div_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] q_res_q, q_res_d;
  logic [DATA_WIDTH-1:0] r_res_q, r_res_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [RemW-1:0]       shifted;
  logic [RemW-1:0]       diff;
  logic                  bor;

  // Shift form drops the partial remainder's top bit, which is always 0 after a restore.
  assign shifted = (rem_q << 1) | RemW'(dvd_q[DATA_WIDTH-1]);

  sub_param #(
    .DATA_WIDTH(RemW)
  ) u_sub (
    .a_in    (shifted),
    .b_in    ({1'b0, dvs_q}),
    .bor_in  (1'b0),
    .diff_out(diff),
    .bor_out (bor)
  );

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_res_d = q_res_q;
    r_res_d = r_res_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start_in) begin
          dvd_d   = bus.dividend_in;
          dvs_d   = bus.divisor_in;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          q_res_d = '0;
          r_res_d = '0;
          state_d = StCalc;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d   = 1'b0;
          if (bus.divisor_in == '0) begin
            state_d = StDone;
            q_res_d = '1;
            r_res_d = bus.dividend_in;
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      StCalc: begin
        dvd_d = dvd_q << 1;
        rem_d = bor ? shifted : diff;
        quo_d = (quo_q << 1) | DATA_WIDTH'(!bor);
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
          state_d = StDone;
          q_res_d = quo_d;
          r_res_d = DATA_WIDTH'(rem_d);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_res_q <= '0;
      r_res_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_res_q <= q_res_d;
      r_res_q <= r_res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end
  assign bus.div_by_zero_out = dbz_q;
`else
  assign bus.div_by_zero_out = 1'b0;
`endif

  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.quotient_out  = q_res_q;
  assign bus.remainder_out = r_res_q;
endmodule
